apb_req_bridge: RTL and testbench

APB_REQ_BRIDGE -- requirements
Module: apb_req_bridge

---
 rtl/apb_bridge_pkg.sv | 15 +
 rtl/apb_bus.sv | 32 +++
 rtl/apb_timeout_cnt.sv | 46 ++++
 rtl/apb_req_bridge.sv | 153 +++++++++++++++
 tb/tb_apb_req_bridge.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared declarations for the request-to-APB bridge.
//   apb_state_e : bridge FSM state (IDLE -> SETUP -> ACCESS -> RESP -> IDLE)
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage : apb_bridge_pkg

// File: rtl/apb_bus.sv
// -----------------------------------------------------------------------------
// APB_BUS
// APB3 signal bundle.
//   Master modport : drives paddr, pwdata, pwrite, psel, penable;
//                    samples prdata, pready, pslverr.
//   Slave modport  : the mirror image.
// -----------------------------------------------------------------------------
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface : APB_BUS

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Counts ACCESS-phase cycles in which the slave has not yet answered.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   clr_i    : clear the count (asserted when a new transfer starts)
//   inc_i    : one more ACCESS cycle without PREADY
//   expire_o : this inc_i brings the count to LIMIT (combinational, so the
//              bridge can leave ACCESS at the end of that same cycle)
// -----------------------------------------------------------------------------
module apb_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count reaches LIMIT on the cycle that increments from LIMIT-1.
  assign expire_o = inc_i && (cnt_q == CW'(LIMIT - 1));

endmodule : apb_timeout_cnt

// File: rtl/apb_req_bridge.sv
// -----------------------------------------------------------------------------
// apb_req_bridge
// Converts a valid/ready request/response pair into single APB transfers.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous active-low reset (aborts any transfer)
//   req_valid_i  : request valid
//   req_ready_o  : high only in IDLE; request taken on valid & ready
//   req_addr_i   : target address
//   req_we_i     : 1 = write, 0 = read
//   req_wdata_i  : write data
//   rsp_valid_o  : response valid, held until rsp_ready_i
//   rsp_ready_i  : response consumed on valid & ready
//   rsp_rdata_o  : read data (0 for writes and timeouts)
//   rsp_err_o    : PSLVERR or timeout
//   apb_master   : APB initiator port
//
// Build option
//   APB_TIMEOUT_EN : adds an ACCESS-phase watchdog (apb_timeout_cnt) that
//                    ends a transfer with an error after TIMEOUT_CYCLES
//                    cycles without PREADY. Without it the bridge waits
//                    in ACCESS indefinitely.
// -----------------------------------------------------------------------------
module apb_req_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_we_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  APB_BUS.Master                    apb_master
);

  apb_state_e                state_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      rsp_err_q;
  logic                      psel_q;
  logic                      penable_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;

  logic                      timeout_hit;

`ifdef APB_TIMEOUT_EN
  // Cleared when a request is accepted (i.e. on SETUP entry), counts every
  // ACCESS cycle that passes without PREADY.
  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    ((state_q == IDLE) && req_valid_i),
    .inc_i    ((state_q == ACCESS) && !apb_master.pready),
    .expire_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // req_ready_q is always 1 here, so valid alone completes the handshake.
          if (req_valid_i) begin
            paddr_q     <= req_addr_i;
            pwrite_q    <= req_we_i;
            pwdata_q    <= req_wdata_i;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end

        ACCESS: begin
          // PREADY is checked first so a reply on the limit cycle completes normally.
          if (apb_master.pready) begin
            rsp_rdata_q <= pwrite_q ? '0 : apb_master.prdata;
            rsp_err_q   <= apb_master.pslverr;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o        = req_ready_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_rdata_o        = rsp_rdata_q;
  assign rsp_err_o          = rsp_err_q;
  assign apb_master.psel    = psel_q;
  assign apb_master.penable = penable_q;
  assign apb_master.paddr   = paddr_q;
  assign apb_master.pwdata  = pwdata_q;
  assign apb_master.pwrite  = pwrite_q;

endmodule : apb_req_bridge

// File: tb/tb_apb_req_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_req_bridge
// Drives requests into apb_req_bridge, plays an APB slave with a chosen
// number of wait states, and compares every cycle of each transfer with the
// phase sequence expected for that transfer. Built with APB_TIMEOUT_EN the
// watchdog limit is 8 cycles.
// -----------------------------------------------------------------------------
module tb_apb_req_bridge;

`ifdef APB_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_if ();

  apb_req_bridge #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .apb_master  (apb_if)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Random slave outputs for cycles where the bridge must ignore them.
  task automatic slave_noise();
    apb_if.pready  = 1'($urandom);
    apb_if.prdata  = $urandom;
    apb_if.pslverr = 1'($urandom);
  endtask

  // One transfer, starting at the negedge of an IDLE cycle and ending at the
  // negedge of the following IDLE cycle. waits = ACCESS cycles with PREADY=0
  // before the slave answers; rsp_delay = RESP cycles with rsp_ready_i=0.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int waits, input logic [31:0] prdata, input logic slverr,
                        input int rsp_delay, input logic hold);
    bit          timed_out;
    int          n_access;
    logic [31:0] exp_rdata;
    logic        exp_err;

    timed_out = (TO_EN != 0) && (waits >= TO);
    n_access  = timed_out ? TO : waits + 1;
    exp_rdata = (we || timed_out) ? 32'd0 : prdata;
    exp_err   = timed_out ? 1'b1 : slverr;

    chk("idle_req_ready", 32'(req_ready_o), 32'd1);
    chk("idle_psel", 32'(apb_if.psel), 32'd0);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_wdata_i = wdata;
    slave_noise();

    @(negedge clk_i);
    chk("setup_psel", 32'(apb_if.psel), 32'd1);
    chk("setup_penable", 32'(apb_if.penable), 32'd0);
    chk("setup_paddr", apb_if.paddr, addr);
    chk("setup_pwrite", 32'(apb_if.pwrite), 32'(we));
    chk("setup_pwdata", apb_if.pwdata, wdata);
    chk("setup_req_ready", 32'(req_ready_o), 32'd0);
    chk("setup_rsp_valid", 32'(rsp_valid_o), 32'd0);
    if (hold) begin
      // Keep a different request pending; it must not be taken while busy.
      req_addr_i  = $urandom;
      req_we_i    = 1'($urandom);
      req_wdata_i = $urandom;
    end else begin
      req_valid_i = 1'b0;
    end
    slave_noise();

    for (int i = 0; i < n_access; i++) begin
      @(negedge clk_i);
      chk("acc_psel", 32'(apb_if.psel), 32'd1);
      chk("acc_penable", 32'(apb_if.penable), 32'd1);
      chk("acc_paddr", apb_if.paddr, addr);
      chk("acc_pwdata", apb_if.pwdata, wdata);
      chk("acc_pwrite", 32'(apb_if.pwrite), 32'(we));
      chk("acc_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("acc_req_ready", 32'(req_ready_o), 32'd0);
      if (!timed_out && i == waits) begin
        apb_if.pready  = 1'b1;
        apb_if.prdata  = prdata;
        apb_if.pslverr = slverr;
      end else begin
        apb_if.pready  = 1'b0;
        apb_if.prdata  = $urandom;
        apb_if.pslverr = 1'($urandom);
      end
    end

    for (int j = 0; j <= rsp_delay; j++) begin
      @(negedge clk_i);
      chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("rsp_rdata", rsp_rdata_o, exp_rdata);
      chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
      chk("rsp_psel", 32'(apb_if.psel), 32'd0);
      chk("rsp_penable", 32'(apb_if.penable), 32'd0);
      chk("rsp_req_ready", 32'(req_ready_o), 32'd0);
      chk("rsp_paddr_kept", apb_if.paddr, addr);
      rsp_ready_i = (j == rsp_delay);
      slave_noise();
    end

    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("done_paddr_kept", apb_if.paddr, addr);
    chk("done_pwdata_kept", apb_if.pwdata, wdata);
  endtask

  initial begin
    rst_ni         = 1'b0;
    req_valid_i    = 1'b0;
    req_addr_i     = '0;
    req_we_i       = 1'b0;
    req_wdata_i    = '0;
    rsp_ready_i    = 1'b0;
    apb_if.pready  = 1'b0;
    apb_if.prdata  = '0;
    apb_if.pslverr = 1'b0;

    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_psel", 32'(apb_if.psel), 32'd0);
    chk("rst_penable", 32'(apb_if.penable), 32'd0);
    chk("rst_paddr", apb_if.paddr, 32'd0);
    chk("rst_pwdata", apb_if.pwdata, 32'd0);
    chk("rst_pwrite", 32'(apb_if.pwrite), 32'd0);

    // Zero-wait write, 3-wait read, error read with stalled response.
    do_txn(32'h1A10_2000, 1'b1, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0, 0, 1'b0);
    do_txn(32'h1A10_0004, 1'b0, 32'h0000_0000, 3, 32'h0000_00A5, 1'b0, 0, 1'b0);
    do_txn(32'h1A10_0008, 1'b0, 32'h0000_0000, 1, 32'hCAFE_F00D, 1'b1, 5, 1'b0);

    // Limit boundary: answer on the 8th ACCESS cycle, then no answer at all
    // (a timeout when the watchdog is built, a late normal reply otherwise).
    do_txn(32'h1A10_0010, 1'b0, 32'h0, TO - 1, 32'h0000_5A5A, 1'b0, 0, 1'b0);
    do_txn(32'h1A10_0014, 1'b0, 32'h0, TO,     32'h0000_3C3C, 1'b0, 1, 1'b0);

    // Reset during ACCESS, with the slave trying to answer on that same edge.
    req_valid_i = 1'b1;
    req_addr_i  = 32'h1A10_0020;
    req_we_i    = 1'b0;
    @(negedge clk_i);
    req_valid_i   = 1'b0;
    apb_if.pready = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_penable", 32'(apb_if.penable), 32'd1);
    rst_ni         = 1'b0;
    apb_if.pready  = 1'b1;
    apb_if.prdata  = 32'h0BAD_0BAD;
    @(negedge clk_i);
    chk("abort_psel", 32'(apb_if.psel), 32'd0);
    chk("abort_penable", 32'(apb_if.penable), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
    rst_ni        = 1'b1;
    apb_if.pready = 1'b0;
    @(negedge clk_i);
    chk("abort_req_ready", 32'(req_ready_o), 32'd1);
    chk("abort_rsp_valid2", 32'(rsp_valid_o), 32'd0);
    chk("abort_paddr", apb_if.paddr, 32'd0);
    do_txn(32'h1A10_0030, 1'b1, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, 0, 1'b0);

    // Back-to-back with valid held high: one transfer every 4 cycles.
    do_txn(32'h2000_0000, 1'b1, 32'h1111_1111, 0, 32'h0, 1'b0, 0, 1'b1);
    do_txn(32'h2000_0004, 1'b0, 32'h0,         0, 32'h2222_2222, 1'b0, 0, 1'b1);
    do_txn(32'h2000_0008, 1'b1, 32'h3333_3333, 0, 32'h0, 1'b0, 0, 1'b1);
    req_valid_i = 1'b0;

    // Randomized transfers.
    for (int k = 0; k < 40; k++) begin
      int          w;
      logic [31:0] a;
      a = $urandom;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                      : int'($urandom_range(0, 3));
      do_txn(a, 1'($urandom), $urandom, w, $urandom,
             ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
             1'($urandom));
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_apb_req_bridge
